transition_histogram: RTL and testbench

//  Windowed bus-transition histogram for the encoded (k+M)-bit bus: per valid beat, counts

---
 rtl/transition_histogram.sv | 130 +++++++++++++
 tb/tb_transition_histogram.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/transition_histogram.sv
// Windowed histogram of bit-toggle counts between successive valid beats of a monitored bus.
// Bins saturate; results stay readable through rd_addr until the next start or reset.
module transition_histogram #(
  parameter int unsigned N     = 37,
  parameter int unsigned CW    = 16,
  parameter int unsigned WIN_W = 16,
  localparam int unsigned AW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic             in_valid,
  input  logic [N-1:0]     data_in,
  input  logic [AW-1:0]    rd_addr,
  output logic [CW-1:0]    rd_data,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [WIN_W-1:0] samples_seen
);

  localparam logic [AW-1:0] MaxAddr = AW'(N);
  localparam logic [CW-1:0] BinMax  = {CW{1'b1}};

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_bins [N+1];
  logic [N-1:0]     r_prev;
  logic [WIN_W-1:0] r_win_len;
  logic [WIN_W-1:0] r_samples;
  logic [CW-1:0]    r_rd_data;
  logic             r_busy;
  logic             r_done;
  logic             r_sat;

  logic [AW-1:0]    w_trans;
  logic             w_last;

  function automatic logic [AW-1:0] popcount(input logic [N-1:0] v);
    logic [AW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = c + AW'(v[i]);
    end
    return c;
  endfunction

  assign w_trans = popcount(data_in ^ r_prev);
  assign w_last  = (r_samples + WIN_W'(1)) == r_win_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      for (int unsigned i = 0; i <= N; i++) begin
        r_bins[i] <= '0;
      end
      r_prev    <= '0;
      r_win_len <= '0;
      r_samples <= '0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      // Reads see the pre-update bin value when the same bin is written this edge.
      r_rd_data <= (rd_addr <= MaxAddr) ? r_bins[rd_addr] : '0;
      case (r_state)
        StIdle: begin
          if (start) begin
            for (int unsigned i = 0; i <= N; i++) begin
              r_bins[i] <= '0;
            end
            r_samples <= '0;
            r_sat     <= 1'b0;
            r_win_len <= window_len;
            if (window_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= StPrime;
              r_busy  <= 1'b1;
            end
          end
        end
        StPrime: begin
          if (abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (in_valid) begin
            r_prev  <= data_in;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (in_valid) begin
            if (r_bins[w_trans] == BinMax) begin
              r_sat <= 1'b1;
            end else begin
              r_bins[w_trans] <= r_bins[w_trans] + CW'(1);
            end
            r_prev    <= data_in;
            r_samples <= r_samples + WIN_W'(1);
            if (w_last) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data      = r_rd_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sat          = r_sat;
  assign samples_seen = r_samples;

endmodule

// File: tb/tb_transition_histogram.sv
// Randomized and directed bench for transition_histogram; expected bins come from the list
// of accepted beats, with a narrow-counter second instance for saturation.
module tb_transition_histogram;

  localparam int NB = 37;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [15:0]     window_len;
  logic            in_valid;
  logic [NB-1:0]   data_in;
  logic [5:0]      rd_addr;
  logic [15:0]     rd_data;
  logic            busy;
  logic            done;
  logic            sat;
  logic [15:0]     samples_seen;
  logic [3:0]      rd_data_s;
  logic            busy_s;
  logic            done_s;
  logic            sat_s;
  logic [15:0]     samples_s;

  int total = 0;
  int bad   = 0;
  logic [NB-1:0] q_beats[$];

  transition_histogram #(.N(NB), .CW(16), .WIN_W(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .window_len   (window_len),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .sat          (sat),
    .samples_seen (samples_seen)
  );

  transition_histogram #(.N(NB), .CW(4), .WIN_W(16)) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .window_len   (window_len),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data_s),
    .busy         (busy_s),
    .done         (done_s),
    .sat          (sat_s),
    .samples_seen (samples_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] rand_bus();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[NB-1:0];
  endfunction

  // Number of accepted transitions whose toggle count equals k.
  function automatic int exp_bin(int k);
    int c = 0;
    for (int i = 1; i < q_beats.size(); i++) begin
      if ($countones(q_beats[i] ^ q_beats[i-1]) == k) c++;
    end
    return c;
  endfunction

  function automatic int exp_samples();
    return (q_beats.size() > 0) ? q_beats.size() - 1 : 0;
  endfunction

  task automatic step(input logic st, input logic ab, input logic [15:0] wl, input logic v,
                      input logic [NB-1:0] d);
    @(negedge clk);
    start      = st;
    abort      = ab;
    window_len = wl;
    in_valid   = v;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'd0, 1'b0, '0);
  endtask

  task automatic beat(input logic [NB-1:0] d);
    step(1'b0, 1'b0, 16'd0, 1'b1, d);
    q_beats.push_back(d);
  endtask

  task automatic start_win(input logic [15:0] wl);
    step(1'b1, 1'b0, wl, 1'b0, '0);
    q_beats.delete();
  endtask

  task automatic check_bins(input string tag);
    int e;
    int addr;
    logic any_sat;
    any_sat = 1'b0;
    for (int a = 0; a < 40; a++) begin
      addr    = (a == 39) ? 63 : a;
      rd_addr = 6'(addr);
      idle();
      e = (addr <= NB) ? exp_bin(addr) : 0;
      if (e > 15) any_sat = 1'b1;
      chk({tag, "_bin"}, 32'(rd_data), 32'(e));
      chk({tag, "_bin4"}, 32'(rd_data_s), 32'((e > 15) ? 15 : e));
    end
    chk({tag, "_sat"}, 32'(sat), 32'(0));
    chk({tag, "_sat4"}, 32'(sat_s), 32'(any_sat));
    chk({tag, "_samples"}, 32'(samples_seen), 32'(exp_samples()));
    chk({tag, "_samples4"}, 32'(samples_s), 32'(exp_samples()));
  endtask

  initial begin
    logic [NB-1:0] d;
    logic [NB-1:0] ones;
    int            wl;
    int            nv;
    int            cyc;
    logic          v;

    ones       = '1;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    window_len = '0;
    in_valid   = 1'b0;
    data_in    = '0;
    rd_addr    = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sat", 32'(sat), 32'(0));
    chk("rst_rd", 32'(rd_data), 32'(0));
    chk("rst_samples", 32'(samples_seen), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed window of three transitions: 37, 0, 36 toggles.
    start_win(16'd3);
    chk("t1_busy", 32'(busy), 32'(1));
    beat('0);
    beat(ones);
    beat(ones);
    chk("t1_nodone", 32'(done), 32'(0));
    beat(37'h1);
    chk("t1_done", 32'(done), 32'(1));
    chk("t1_busy_end", 32'(busy), 32'(0));
    chk("t1_samples", 32'(samples_seen), 32'(3));
    idle();
    chk("t1_done_pulse", 32'(done), 32'(0));
    check_bins("t1");

    // Zero-length window.
    start_win(16'd0);
    chk("t2_busy", 32'(busy), 32'(0));
    chk("t2_done", 32'(done), 32'(1));
    idle();
    chk("t2_done_pulse", 32'(done), 32'(0));
    check_bins("t2");

    // Twenty identical transitions saturate the 4-bit instance.
    d = rand_bus();
    start_win(16'd20);
    for (int i = 0; i < 21; i++) beat(d);
    chk("t3_done", 32'(done), 32'(1));
    chk("t3_done4", 32'(done_s), 32'(1));
    check_bins("t3");

    // Abort after two transitions; the beat in the abort cycle is dropped.
    start_win(16'd10);
    beat(37'h0);
    beat(37'h1);
    beat(37'h3);
    step(1'b0, 1'b1, 16'd0, 1'b1, 37'h7);
    chk("t4_busy", 32'(busy), 32'(0));
    chk("t4_done", 32'(done), 32'(0));
    idle();
    chk("t4_done_late", 32'(done), 32'(0));
    check_bins("t4");
    step(1'b1, 1'b1, 16'd5, 1'b0, '0);
    q_beats.delete();
    chk("t4_start_abort_idle", 32'(busy), 32'(1));
    check_bins("t4_clear");
    step(1'b1, 1'b0, 16'd0, 1'b0, '0);
    chk("t4_start_busy_ign", 32'(busy), 32'(1));
    chk("t4_start_busy_nodone", 32'(done), 32'(0));
    step(1'b0, 1'b1, 16'd0, 1'b0, '0);
    chk("t4_abort2", 32'(busy), 32'(0));

    // Alternating valid with data changing every cycle.
    start_win(16'd4);
    for (int c = 0; c < 10; c++) begin
      v = (c % 2 == 0);
      d = rand_bus();
      step(1'b0, 1'b0, 16'd0, v, d);
      if (v) q_beats.push_back(d);
      chk("t5_done", 32'(done), 32'(c == 8));
    end
    check_bins("t5");

    // Random windows with sparse valid.
    for (int w = 0; w < 5; w++) begin
      wl = $urandom_range(1, 30);
      start_win(16'(wl));
      nv  = 0;
      cyc = 0;
      while (nv < wl + 1 && cyc < 500) begin
        v = ($urandom_range(0, 3) != 0);
        d = (w % 2 == 0) ? rand_bus() : NB'($urandom_range(0, 7));
        step(1'b0, 1'b0, 16'd0, v, d);
        if (v) begin
          q_beats.push_back(d);
          nv++;
        end
        cyc++;
        chk("rnd_done", 32'(done), 32'(v && nv == wl + 1));
        chk("rnd_busy", 32'(busy), 32'(nv != wl + 1));
      end
      chk("rnd_bound", 32'(nv), 32'(wl + 1));
      check_bins("rnd");
    end

    // Asynchronous reset between edges in the middle of a window.
    rd_addr = 6'd0;
    start_win(16'd5);
    d = rand_bus();
    beat(d);
    beat(d);
    beat(d);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_done", 32'(done), 32'(0));
    chk("t6_sat", 32'(sat), 32'(0));
    chk("t6_rd", 32'(rd_data), 32'(0));
    chk("t6_samples", 32'(samples_seen), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_win(16'd1);
    beat(rand_bus());
    chk("t6_nodone", 32'(done), 32'(0));
    beat(rand_bus());
    chk("t6_done2", 32'(done), 32'(1));
    check_bins("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
